// File: rtl/alertness_monitor_n.sv
// alertness_monitor_n: randomised operator prompt with escalation and alarm.
// Includes response latency reporting, a miss counter and a stuck-button watchdog.
//
// Ports:
//   clock       single clock, rising edge
//   reset       asynchronous active-low reset
//   in_put      response button, synchronous to clock
//   stage_led   one-hot prompt stage indicator
//   alarm       alarm lamp
//   ring        bell: in ALARM, or in IDLE while the button is held
//   rsp_valid   one-cycle pulse per accepted response
//   rsp_latency latency of the last accepted response, held
//   miss_count  saturating count of ALARM entries
//   wdt_fault   sticky watchdog-fired flag
module alertness_monitor_n #(
  parameter int                LFSR_W        = 8,
  parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(8'hB8),
  parameter int                WAIT_SCALE    = 10,
  parameter int                STAGES        = 3,
  parameter int                PROMPT_CYCLES = 10,
  parameter int                WDT_LIMIT     = 4096,
  parameter int                LAT_W         = 12,
  parameter int                MISS_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_put,
  output logic [STAGES-1:0] stage_led,
  output logic              alarm,
  output logic              ring,
  output logic              rsp_valid,
  output logic [LAT_W-1:0]  rsp_latency,
  output logic [MISS_W-1:0] miss_count,
  output logic              wdt_fault
);

  localparam int SW = $clog2(STAGES + 2);
  localparam int CW = LFSR_W + $clog2(WAIT_SCALE) + 1;
  localparam int WW = $clog2(WDT_LIMIT);

  localparam logic [SW-1:0] S_IDLE  = '0;
  localparam logic [SW-1:0] S_P0    = SW'(1);
  localparam logic [SW-1:0] S_PL    = SW'(STAGES);
  localparam logic [SW-1:0] S_ALARM = SW'(STAGES + 1);

  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_PROMPT = CW'(PROMPT_CYCLES);
  localparam logic [CW-1:0] C_SCALE  = CW'(WAIT_SCALE);
  localparam logic [WW-1:0] W_LAST   = WW'(WDT_LIMIT - 1);

  logic [SW-1:0]     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wdt_q, wdt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [LAT_W-1:0]  rlat_q, rlat_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] hold_q, hold_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              in_q;
  logic              rv_q, rv_d;
  logic              fault_q, fault_d;

  logic              rise;
  logic              idle_s, prompt_s, alarm_s;
  logic              accept;
  logic [CW-1:0]     quiet;
  logic [LAT_W-1:0]  lat_inc;
  logic [MISS_W-1:0] miss_inc;

  assign rise     = in_put & ~in_q;
  assign idle_s   = (state_q == S_IDLE);
  assign alarm_s  = (state_q == S_ALARM);
  assign prompt_s = (state_q >= S_P0) && (state_q <= S_PL);
  assign quiet    = CW'(hold_q) * C_SCALE;
  assign lat_inc  = (&lat_q) ? lat_q : lat_q + 1'b1;
  assign miss_inc = (&miss_q) ? miss_q : miss_q + 1'b1;
  assign lfsr_d   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    hold_d  = hold_q;
    rv_d    = 1'b0;
    rlat_d  = rlat_q;
    miss_d  = miss_q;
    fault_d = fault_q;
    accept  = 1'b0;

    unique case (1'b1)
      idle_s: begin
        if (!in_put) begin
          if (cnt_q < quiet) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = S_P0;
            cnt_d   = C_ONE;
            lat_d   = '0;
          end
        end
      end
      prompt_s: begin
        lat_d = lat_inc;
        if (rise) begin
          accept = 1'b1;
        end else if (cnt_q == C_PROMPT) begin
          cnt_d = C_ONE;
          if (state_q == S_PL) begin
            state_d = S_ALARM;
            miss_d  = miss_inc;
          end else begin
            state_d = state_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      alarm_s: begin
        lat_d = lat_inc;
        if (rise) accept = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = C_ONE;
      end
    endcase

    if (accept) begin
      state_d = S_IDLE;
      cnt_d   = C_ONE;
      rv_d    = 1'b1;
      rlat_d  = lat_inc;
      hold_d  = lfsr_q;
    end

    // ALARM is a legitimate indefinite wait, so the watchdog idles there.
    if (alarm_s || (state_d != state_q)) begin
      wdt_d = '0;
    end else begin
      wdt_d = wdt_q + 1'b1;
    end

    // Expiry overrides whatever else this cycle decided.
    if (!alarm_s && (wdt_q == W_LAST)) begin
      fault_d = 1'b1;
      state_d = S_IDLE;
      cnt_d   = C_ONE;
      wdt_d   = '0;
      hold_d  = lfsr_q;
      rv_d    = 1'b0;
      rlat_d  = rlat_q;
      miss_d  = miss_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= C_ONE;
      wdt_q   <= '0;
      lat_q   <= '0;
      rlat_q  <= '0;
      lfsr_q  <= '1;
      hold_q  <= '1;
      miss_q  <= '0;
      in_q    <= 1'b0;
      rv_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdt_q   <= wdt_d;
      lat_q   <= lat_d;
      rlat_q  <= rlat_d;
      lfsr_q  <= lfsr_d;
      hold_q  <= hold_d;
      miss_q  <= miss_d;
      in_q    <= in_put;
      rv_q    <= rv_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_led[k] = (state_q == SW'(k + 1));
    end
  end

  assign alarm       = alarm_s;
  assign ring        = alarm_s | (idle_s & in_put);
  assign rsp_valid   = rv_q;
  assign rsp_latency = rlat_q;
  assign miss_count  = miss_q;
  assign wdt_fault   = fault_q;

endmodule

// File: tb/tb_alertness_monitor_n.sv
// tb_alertness_monitor_n: directed and random stimulus for alertness_monitor_n,
// checked every cycle against a phase-level behavioural model.
module tb_alertness_monitor_n;

  localparam int LW  = 4;
  localparam int WS  = 2;
  localparam int NS  = 2;
  localparam int PC  = 4;
  localparam int WDT = 64;
  localparam int LTW = 8;
  localparam int MW  = 2;
  localparam int LAT_MAX  = (1 << LTW) - 1;
  localparam int MISS_MAX = (1 << MW) - 1;
  localparam int PH_ALARM = NS + 1;
  localparam logic [LW-1:0] TP = 4'b1001;

  logic clk;
  logic rst_n;
  logic in_put;
  logic [NS-1:0] stage_led;
  logic alarm;
  logic ring;
  logic rsp_valid;
  logic [LTW-1:0] rsp_latency;
  logic [MW-1:0] miss_count;
  logic wdt_fault;

  int ncmp = 0;
  int nerr = 0;

  alertness_monitor_n #(
    .LFSR_W(LW), .TAPS(TP), .WAIT_SCALE(WS), .STAGES(NS),
    .PROMPT_CYCLES(PC), .WDT_LIMIT(WDT), .LAT_W(LTW), .MISS_W(MW)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .in_put(in_put),
    .stage_led(stage_led),
    .alarm(alarm),
    .ring(ring),
    .rsp_valid(rsp_valid),
    .rsp_latency(rsp_latency),
    .miss_count(miss_count),
    .wdt_fault(wdt_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level model: 0 = quiet, 1..NS = prompt stages, NS+1 = alarm.
  int m_lfsr, m_hold, m_phase;
  int m_idle_low, m_stage_t, m_since, m_age, m_miss, m_rlat;
  bit m_fault, m_rv, m_prev;

  function automatic int lfsr_next(input int x);
    logic [LW-1:0] v;
    v = x[LW-1:0];
    return int'({v[LW-2:0], ^(v & TP)});
  endfunction

  task automatic m_reset();
    m_lfsr = (1 << LW) - 1;
    m_hold = (1 << LW) - 1;
    m_phase = 0;
    m_idle_low = 0;
    m_stage_t = 0;
    m_since = 0;
    m_age = 0;
    m_miss = 0;
    m_rlat = 0;
    m_fault = 0;
    m_rv = 0;
    m_prev = 0;
  endtask

  task automatic m_step();
    bit rise;
    bit fire;
    int old;
    rise = in_put && !m_prev;
    old = m_phase;
    fire = 0;
    m_rv = 0;
    if (m_phase != PH_ALARM && m_age == WDT - 1) begin
      fire = 1;
      m_fault = 1;
      m_phase = 0;
      m_hold = m_lfsr;
      m_idle_low = 0;
    end else if (m_phase == 0) begin
      if (!in_put) begin
        if (m_idle_low + 1 == m_hold * WS) begin
          m_phase = 1;
          m_stage_t = 0;
          m_since = 0;
        end else begin
          m_idle_low++;
        end
      end
    end else if (rise) begin
      m_rv = 1;
      m_rlat = (m_since + 1 > LAT_MAX) ? LAT_MAX : m_since + 1;
      m_hold = m_lfsr;
      m_phase = 0;
      m_idle_low = 0;
    end else begin
      if (m_phase <= NS) begin
        if (m_stage_t + 1 == PC) begin
          m_stage_t = 0;
          m_phase++;
          if (m_phase == PH_ALARM && m_miss < MISS_MAX) m_miss++;
        end else begin
          m_stage_t++;
        end
      end
      if (m_since < LAT_MAX) m_since++;
    end
    if (fire || m_phase != old || m_phase == PH_ALARM) m_age = 0;
    else m_age++;
    m_lfsr = lfsr_next(m_lfsr);
    m_prev = in_put;
  endtask

  task automatic compare_all();
    int exp_led;
    bit exp_alarm;
    exp_led = (m_phase >= 1 && m_phase <= NS) ? (1 << (m_phase - 1)) : 0;
    exp_alarm = (m_phase == PH_ALARM);
    chk("stage_led", int'(stage_led), exp_led);
    chk("alarm", int'(alarm), int'(exp_alarm));
    chk("ring", int'(ring), int'(exp_alarm | (m_phase == 0 && in_put)));
    chk("rsp_valid", int'(rsp_valid), int'(m_rv));
    chk("rsp_latency", int'(rsp_latency), m_rlat);
    chk("miss_count", int'(miss_count), m_miss);
    chk("wdt_fault", int'(wdt_fault), int'(m_fault));
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
    #1;
    compare_all();
  end

  // what: 0 = first P0 cycle, 1 = first P1 cycle, 2 = alarm
  task automatic wait_until(input int what, input int limit);
    bit hit;
    hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (what)
        0: hit = (stage_led == 2'b01);
        1: hit = (stage_led == 2'b10);
        default: hit = alarm;
      endcase
    end
    if (!hit) begin
      ncmp++;
      nerr++;
      $display("FAIL wait_%0d: got timeout expected event within %0d", what, limit);
    end
  endtask

  task automatic press_once();
    @(negedge clk);
    in_put = 1'b1;
    @(negedge clk);
    in_put = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_put = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", int'(stage_led), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_lat", int'(rsp_latency), 0);
    chk("rst_miss", int'(miss_count), 0);
    chk("rst_fault", int'(wdt_fault), 0);
    chk("rst_ring0", int'(ring), 0);
    in_put = 1'b1;
    #1 chk("rst_ring1", int'(ring), 1);
    @(negedge clk);
    in_put = 1'b0;

    // No response: 30 quiet cycles, 4+4 prompt cycles, then alarm.
    rst_n = 1'b1;
    repeat (29) @(negedge clk);
    chk("quiet29", int'(stage_led), 0);
    @(negedge clk);
    chk("p0_entry", int'(stage_led), 1);
    repeat (4) @(negedge clk);
    chk("p1_entry", int'(stage_led), 2);
    repeat (4) @(negedge clk);
    chk("alarm_entry", int'(alarm), 1);
    chk("alarm_ring", int'(ring), 1);
    chk("alarm_miss", int'(miss_count), 1);
    chk("alarm_fault", int'(wdt_fault), 0);

    // Press in the 5th alarm cycle.
    repeat (4) @(negedge clk);
    in_put = 1'b1;
    @(negedge clk);
    chk("alarm_rv", int'(rsp_valid), 1);
    chk("alarm_lat", int'(rsp_latency), 13);
    chk("alarm_exit", int'(alarm), 0);
    in_put = 1'b0;

    // Four more escalations saturate the miss counter.
    for (int r = 0; r < 4; r++) begin
      wait_until(2, 200);
      press_once();
    end
    chk("miss_sat", int'(miss_count), 3);

    // Fast response on the first P0 cycle.
    wait_until(0, 200);
    in_put = 1'b1;
    @(negedge clk);
    chk("fast_rv", int'(rsp_valid), 1);
    chk("fast_lat", int'(rsp_latency), 1);
    in_put = 1'b0;

    // Respond in P0, keep holding into the quiet phase, then answer in P1.
    wait_until(0, 200);
    in_put = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_ring", int'(ring), 1);
    chk("held_no_rv", int'(rsp_valid), 0);
    in_put = 1'b0;
    wait_until(1, 200);
    in_put = 1'b1;
    @(negedge clk);
    chk("p1_rv", int'(rsp_valid), 1);
    chk("p1_lat", int'(rsp_latency), 5);
    in_put = 1'b0;

    // Random button activity.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) in_put = ~in_put;
    end
    in_put = 1'b0;

    // Stuck button from reset release.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    in_put = 1'b1;
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    chk("wdt_pre", int'(wdt_fault), 0);
    @(negedge clk);
    chk("wdt_fire", int'(wdt_fault), 1);
    chk("wdt_ring", int'(ring), 1);
    repeat (6) @(negedge clk);
    in_put = 1'b0;

    // Two alarms, then reset asynchronously in the middle of the second.
    wait_until(2, 200);
    press_once();
    wait_until(2, 200);
    repeat (2) @(negedge clk);
    chk("pre_rst_miss", int'(miss_count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alarm", int'(alarm), 0);
    chk("arst_ring", int'(ring), 0);
    chk("arst_led", int'(stage_led), 0);
    chk("arst_miss", int'(miss_count), 0);
    chk("arst_fault", int'(wdt_fault), 0);
    chk("arst_lat", int'(rsp_latency), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (29) @(negedge clk);
    chk("rel_quiet29", int'(stage_led), 0);
    @(negedge clk);
    chk("rel_p0", int'(stage_led), 1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
